ahb_arbiter: RTL and testbench
==============================

AHB_ARBITER -- requirements
Module: ahb_arbiter

Interface
REQ-001 Parameter NUM_MASTERS, default 4: number of requesting masters, 2..4.
REQ-002 Parameter PARK_MASTER, default 0: master index granted when nobody requests.
REQ-003 Port hclk  input  1: bus clock; all state updates on its rising edge.
REQ-004 Port hresetn  input  1: reset, synchronous and active-low, sampled on the rising edge of hclk.
REQ-005 Port hbusreq  input  NUM_MASTERS: per-master bus request, bit i = master i.
REQ-006 Port hlock  input  NUM_MASTERS: per-master locked-transfer request, bit i = master i.
REQ-007 Port htrans  input  2: transfer type driven by the current address-phase owner (IDLE 00, BUSY 01, NONSEQ 10, SEQ 11).
REQ-008 Port hready  input  1: slave ready, high = current data phase completes this cycle.
REQ-009 Port hgrant  output  NUM_MASTERS: one-hot grant, registered.
REQ-010 Port hmaster  output  2: index of the master owning the address phase, registered.
REQ-011 Port hmastlock  output  1: current address phase belongs to a locked sequence, registered.

Function
REQ-012 hgrant is one-hot in every cycle out of reset and never all-zero.
REQ-013 Arbitration is evaluated only in cycles with hready=1; with hready=0, hgrant, hmaster and hmastlock hold.
REQ-014 Two states: PARK (no hbusreq bit set; grant on PARK_MASTER) and OWN (grant on a requesting master).
REQ-015 PARK->OWN: in an hready=1 cycle with any hbusreq bit set, hgrant moves to the winner at the next edge.
REQ-016 OWN->PARK: in an hready=1 cycle with hbusreq all-zero and htrans IDLE or NONSEQ, hgrant moves to PARK_MASTER at the next edge.
REQ-017 Burst hold: when htrans is SEQ or BUSY, the grant does not change regardless of requests.
REQ-018 Winner selection is round-robin: search starts at (last_owner+1) mod NUM_MASTERS; the first set hbusreq bit wins; last_owner updates on every grant change.
REQ-019 An owner that still requests at an IDLE/NONSEQ boundary loses the grant if any other master requests, and keeps it otherwise.
REQ-020 hmaster takes the index of the current hgrant at each edge with hready=1, i.e. one hready-qualified cycle after the grant (AHB address-phase handover).
REQ-021 hmastlock takes hlock[granted index] on the same edge as hmaster.
REQ-022 hbusreq/hlock bits at or above NUM_MASTERS are ignored.
REQ-023 Simultaneous requests at a boundary: the round-robin order decides; ties are impossible by construction.

Reset
REQ-024 With hresetn=0 at a rising edge: hgrant = one-hot PARK_MASTER, hmaster = PARK_MASTER, hmastlock = 0, last_owner = PARK_MASTER, state = PARK.
REQ-025 Reset asserted mid-burst or mid-lock overrides all holds and takes effect at that edge.
REQ-026 First arbitration follows in the first hready=1 cycle after hresetn=1.

Configuration
REQ-027 Macro AHB_ARBITER_LOCK_EN.
REQ-028 With AHB_ARBITER_LOCK_EN defined: while the owner's hlock bit is 1, its grant is held at IDLE/NONSEQ boundaries even if others request; the grant is released at the first hready=1 boundary after hlock drops.
REQ-029 Without AHB_ARBITER_LOCK_EN: hlock is ignored, and hmastlock is constant 0.

Verification
REQ-030 Reset with hbusreq=0 -> hgrant=0001, hmaster=0, hmastlock=0; stays parked for 10 cycles.
REQ-031 hbusreq=0110 held, htrans=NONSEQ, hready=1 -> grants cycle 0010, 0100, 0010 on successive edges; hmaster trails by one cycle.
REQ-032 Master 1 owns, htrans=SEQ for 4 beats, hbusreq=0111 -> hgrant stays 0010 until htrans returns to NONSEQ/IDLE, then 0100.
REQ-033 hready=0 for 3 cycles while hbusreq changes -> hgrant/hmaster frozen; update on the first hready=1 edge.
REQ-034 LOCK_EN build: master 2 has hlock=1 with hbusreq=1111 -> hgrant stays 0100 and hmastlock=1 until hlock drops, then 1000. Without the macro -> normal rotation and hmastlock=0.
REQ-035 hresetn=0 during master 3's burst -> at the next edge hgrant=0001, hmaster=0, hmastlock=0.

Source files
------------

// File: rtl/ahb_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_arbiter -- AHB bus arbiter with parking, round-robin and burst hold.
//
// Parameters:
//   NUM_MASTERS  number of requesting masters (2..4)
//   PARK_MASTER  master granted when nobody requests
//
// Ports:
//   hclk       bus clock, all state updates on rising edge
//   hresetn    synchronous active-low reset
//   hbusreq    per-master bus request
//   hlock      per-master locked-transfer request
//   htrans     transfer type of the current address-phase owner
//   hready     slave ready; arbitration happens only when high
//   hgrant     one-hot grant (registered)
//   hmaster    address-phase owner index (registered)
//   hmastlock  address phase belongs to a locked sequence (registered)
//
// Build option: define AHB_ARBITER_LOCK_EN to honour hlock (grant held while
// the owner keeps hlock asserted). Without it hlock is ignored and hmastlock
// is constant 0.
// ---------------------------------------------------------------------------
module ahb_arbiter #(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned PARK_MASTER = 0
) (
    input  logic                   hclk,
    input  logic                   hresetn,
    input  logic [NUM_MASTERS-1:0] hbusreq,
    input  logic [NUM_MASTERS-1:0] hlock,
    input  logic [1:0]             htrans,
    input  logic                   hready,
    output logic [NUM_MASTERS-1:0] hgrant,
    output logic [1:0]             hmaster,
    output logic                   hmastlock
);

    localparam int unsigned IDX_W = 2;
    localparam logic [1:0] HTRANS_BUSY = 2'b01;
    localparam logic [1:0] HTRANS_SEQ  = 2'b11;
    localparam logic [IDX_W-1:0] PARK_IDX = IDX_W'(PARK_MASTER);
    localparam logic [NUM_MASTERS-1:0] PARK_GRANT = NUM_MASTERS'(1) << PARK_MASTER;

    typedef enum logic {
        ST_PARK,
        ST_OWN
    } state_e;

    state_e                 state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]       owner_q, owner_d;   // last owner == current grant index
    logic [IDX_W-1:0]       hmaster_q;
    logic                   hmastlock_q;

    // Requests padded to 4 bits so a 2-bit index is always in range.
    logic [3:0]       req4_c;
    logic [3:0]       lock4_c;
    logic [IDX_W-1:0] winner_c;
    logic             found_c;
    logic             hold_c;

    assign req4_c  = 4'(hbusreq);
    assign lock4_c = 4'(hlock);

`ifndef AHB_ARBITER_LOCK_EN
    logic unused_lock_c;
    assign unused_lock_c = ^lock4_c;
`endif

    // Round-robin search starting one past the last owner.
    always_comb begin
        logic [IDX_W-1:0] idx;
        winner_c = owner_q;
        found_c  = 1'b0;
        idx      = '0;
        for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
            idx = IDX_W'((32'(owner_q) + k) % NUM_MASTERS);
            if (!found_c && req4_c[idx]) begin
                winner_c = idx;
                found_c  = 1'b1;
            end
        end
    end

    // Next grant / state decision at hready boundaries.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        hold_c  = (htrans == HTRANS_BUSY) || (htrans == HTRANS_SEQ);
`ifdef AHB_ARBITER_LOCK_EN
        if (state_q == ST_OWN && lock4_c[owner_q]) begin
            hold_c = 1'b1;
        end
`endif
        if (hready && !hold_c) begin
            if (found_c) begin
                state_d = ST_OWN;
                owner_d = winner_c;
                grant_d = NUM_MASTERS'(1) << winner_c;
            end else begin
                state_d = ST_PARK;
                owner_d = PARK_IDX;
                grant_d = PARK_GRANT;
            end
        end
    end

    // State and output registers; hmaster trails the grant by one ready cycle.
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state_q     <= ST_PARK;
            grant_q     <= PARK_GRANT;
            owner_q     <= PARK_IDX;
            hmaster_q   <= PARK_IDX;
            hmastlock_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            if (hready) begin
                hmaster_q <= owner_q;
`ifdef AHB_ARBITER_LOCK_EN
                hmastlock_q <= lock4_c[owner_q];
`else
                hmastlock_q <= 1'b0;
`endif
            end
        end
    end

    assign hgrant    = grant_q;
    assign hmaster   = hmaster_q;
    assign hmastlock = hmastlock_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ahb_arbiter -- scoreboard bench for ahb_arbiter (NUM_MASTERS=4, park 0).
// Stimulus drives inputs on the falling edge and pushes the expected
// post-edge outputs from a behavioural model; a monitor pops and compares
// just after each rising edge. Honours AHB_ARBITER_LOCK_EN like the DUT.
// ---------------------------------------------------------------------------
module tb_ahb_arbiter;

    localparam int N    = 4;
    localparam int PARK = 0;
    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_BUSY   = 2'b01;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

    logic         hclk = 1'b0;
    logic         hresetn;
    logic [N-1:0] hbusreq;
    logic [N-1:0] hlock;
    logic [1:0]   htrans;
    logic         hready;
    logic [N-1:0] hgrant;
    logic [1:0]   hmaster;
    logic         hmastlock;

    ahb_arbiter #(.NUM_MASTERS(N), .PARK_MASTER(PARK)) dut (
        .hclk      (hclk),
        .hresetn   (hresetn),
        .hbusreq   (hbusreq),
        .hlock     (hlock),
        .htrans    (htrans),
        .hready    (hready),
        .hgrant    (hgrant),
        .hmaster   (hmaster),
        .hmastlock (hmastlock)
    );

    always #5 hclk = ~hclk;

    typedef struct packed {
        logic [N-1:0] grant;
        logic [1:0]   master;
        logic         lock;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Reference model state: who holds the grant, who owns the address phase.
    int m_grant_idx;
    int m_master;
    bit m_mastlock;
    bit m_owned;

    task automatic step(input bit rst_n, input logic [N-1:0] req,
                        input logic [N-1:0] lck, input logic [1:0] trans,
                        input bit rdy);
        bit   burst;
        bit   locked;
        int   new_master;
        bit   new_lock;
        exp_t e;
        @(negedge hclk);
        hresetn = rst_n;
        hbusreq = req;
        hlock   = lck;
        htrans  = trans;
        hready  = rdy;
        if (!rst_n) begin
            m_grant_idx = PARK;
            m_master    = PARK;
            m_mastlock  = 1'b0;
            m_owned     = 1'b0;
        end else if (rdy) begin
            new_master = m_grant_idx;
`ifdef AHB_ARBITER_LOCK_EN
            new_lock = lck[m_grant_idx];
            locked   = m_owned && lck[m_grant_idx];
`else
            new_lock = 1'b0;
            locked   = 1'b0;
`endif
            burst = (trans == T_SEQ) || (trans == T_BUSY);
            if (!burst && !locked) begin
                if (req != '0) begin
                    for (int k = 1; k <= N; k++) begin
                        int cand;
                        cand = (m_grant_idx + k) % N;
                        if (req[cand]) begin
                            m_grant_idx = cand;
                            break;
                        end
                    end
                    m_owned = 1'b1;
                end else begin
                    m_grant_idx = PARK;
                    m_owned     = 1'b0;
                end
            end
            m_master   = new_master;
            m_mastlock = new_lock;
        end
        e.grant  = N'(1) << m_grant_idx;
        e.master = 2'(m_master);
        e.lock   = m_mastlock;
        exp_q.push_back(e);
    endtask

    // Monitor: compare DUT outputs against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge hclk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (hgrant !== e.grant) begin
                    errors++;
                    $display("FAIL hgrant cyc %0d got %b exp %b", cyc, hgrant, e.grant);
                end
                checks++;
                if (hmaster !== e.master) begin
                    errors++;
                    $display("FAIL hmaster cyc %0d got %0d exp %0d", cyc, hmaster, e.master);
                end
                checks++;
                if (hmastlock !== e.lock) begin
                    errors++;
                    $display("FAIL hmastlock cyc %0d got %b exp %b", cyc, hmastlock, e.lock);
                end
                checks++;
                if (!$onehot(hgrant)) begin
                    errors++;
                    $display("FAIL onehot cyc %0d got %b exp one-hot", cyc, hgrant);
                end
            end
        end
    end

    initial begin
        logic [N-1:0] r_req;
        logic [N-1:0] r_lck;
        logic [1:0]   r_trans;
        bit           r_rdy;
        bit           r_rst;
        hresetn = 1'b0;
        hbusreq = '0;
        hlock   = '0;
        htrans  = T_IDLE;
        hready  = 1'b1;
        m_grant_idx = PARK;
        m_master    = PARK;
        m_mastlock  = 1'b0;
        m_owned     = 1'b0;

        // Reset, then parked for 10 cycles with no requests.
        repeat (2) step(1'b0, 4'b0000, 4'b0000, T_IDLE, 1'b1);
        repeat (10) step(1'b1, 4'b0000, 4'b0000, T_IDLE, 1'b1);

        // Two requesters rotate on NONSEQ boundaries.
        repeat (4) step(1'b1, 4'b0110, 4'b0000, T_NONSEQ, 1'b1);

        // Master 1 owns, SEQ burst holds the grant, then hands to master 2.
        step(1'b1, 4'b0010, 4'b0000, T_NONSEQ, 1'b1);
        repeat (4) step(1'b1, 4'b0111, 4'b0000, T_SEQ, 1'b1);
        repeat (2) step(1'b1, 4'b0111, 4'b0000, T_NONSEQ, 1'b1);

        // hready low freezes everything while requests change.
        step(1'b1, 4'b1000, 4'b0000, T_NONSEQ, 1'b0);
        step(1'b1, 4'b0001, 4'b0000, T_IDLE,   1'b0);
        step(1'b1, 4'b1001, 4'b0000, T_NONSEQ, 1'b0);
        step(1'b1, 4'b1001, 4'b0000, T_NONSEQ, 1'b1);
        step(1'b1, 4'b0000, 4'b0000, T_IDLE,   1'b1);

        // Master 2 locked with everyone requesting, then lock drops.
        step(1'b1, 4'b0100, 4'b0000, T_NONSEQ, 1'b1);
        repeat (4) step(1'b1, 4'b1111, 4'b0100, T_NONSEQ, 1'b1);
        repeat (3) step(1'b1, 4'b1111, 4'b0000, T_NONSEQ, 1'b1);

        // Reset in the middle of master 3's burst.
        step(1'b1, 4'b1000, 4'b0000, T_NONSEQ, 1'b1);
        repeat (2) step(1'b1, 4'b1111, 4'b1000, T_SEQ, 1'b1);
        step(1'b0, 4'b1111, 4'b1000, T_SEQ, 1'b1);
        step(1'b1, 4'b0000, 4'b0000, T_IDLE, 1'b1);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            r_req   = N'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) r_req = '0;
            r_lck   = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 15)) : '0;
            r_trans = 2'($urandom_range(0, 3));
            r_rdy   = ($urandom_range(0, 3) != 0);
            r_rst   = ($urandom_range(0, 63) != 0);
            step(r_rst, r_req, r_lck, r_trans, r_rdy);
        end

        repeat (3) @(negedge hclk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
